// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and shared constants for the pipeline control unit
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_REDIR = 2'b11
  } state_t;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and the ID sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);
  assign hazard = ex_mem_read && ex_rd != REG_ZERO &&
                  (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: next-PC select, load-use stall gating, redirect squash, boot hold and hazard statistics
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          BOOT_CYCLES = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rd,
  input  logic        MEM_PCSrc,
  input  logic [31:0] MEM_Btarg_or_Jtarg,
  input  logic [31:0] IF_PC4,
  output logic [31:0] PC_Next,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic [1:0]  Ctrl_State,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt
);
  state_t     state, next;
  logic [3:0] boot_cnt;
  logic       hazard, boot, redir, stall;
  hazard_detect u_hd (
    .id_rs      (ID_Rs),
    .id_rt      (ID_Rt),
    .id_uses_rt (ID_UsesRt),
    .ex_mem_read(EX_MemRead),
    .ex_rd      (EX_Rd),
    .hazard     (hazard)
  );
  assign Ctrl_State = state;
  always_comb begin
    boot        = state == ST_BOOT;
    redir       = !boot && MEM_PCSrc;
    stall       = !boot && !MEM_PCSrc && hazard;
    PC_Next     = boot ? RESET_PC : MEM_PCSrc ? MEM_Btarg_or_Jtarg : IF_PC4;
    PC_Write    = !boot && !stall;
    IFID_Write  = !boot && !stall;
    IFID_Flush  = boot || redir;
    IDEX_Flush  = boot || redir || stall;
    EXMEM_Flush = boot || redir;
    next        = boot ? (boot_cnt == 4'(BOOT_CYCLES - 1) ? ST_RUN : ST_BOOT) :
                  redir ? ST_REDIR : stall ? ST_STALL : ST_RUN;
  end
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= ST_BOOT;
      boot_cnt  <= 4'd0;
      Stall_Cnt <= 32'd0;
      Flush_Cnt <= 32'd0;
    end else begin
      state     <= next;
      boot_cnt  <= boot ? boot_cnt + 4'd1 : 4'd0;
      if (redir && Flush_Cnt != CNT_MAX) Flush_Cnt <= Flush_Cnt + 32'd1;
      if (stall && Stall_Cnt != CNT_MAX) Stall_Cnt <= Stall_Cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;
  localparam int          BC   = 3;
  localparam logic [31:0] RPC  = 32'hBFC0_0000;
  localparam logic [31:0] MAXC = 32'hFFFF_FFFF;
  logic        clk = 1'b0, clr;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_mem_read, mem_pcsrc;
  logic [31:0] targ, pc4;
  logic [31:0] pc_next, stall_cnt, flush_cnt;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  ctrl_state;
  int          vectors = 0, miscompares = 0;
  int          m_st, m_left;
  logic [31:0] m_sc, m_fc;
  bit          armed = 0;
  pipe_ctrl #(.BOOT_CYCLES(BC), .RESET_PC(RPC)) dut (
    .Clk(clk), .Clr(clr), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
    .EX_MemRead(ex_mem_read), .EX_Rd(ex_rd), .MEM_PCSrc(mem_pcsrc),
    .MEM_Btarg_or_Jtarg(targ), .IF_PC4(pc4), .PC_Next(pc_next), .PC_Write(pc_write),
    .IFID_Write(ifid_write), .IFID_Flush(ifid_flush), .IDEX_Flush(idex_flush),
    .EXMEM_Flush(exmem_flush), .Ctrl_State(ctrl_state), .Stall_Cnt(stall_cnt),
    .Flush_Cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit model_hazard();
    return ex_mem_read && ex_rd != 0 &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  endfunction
  task automatic drive(input bit c, input bit mr, input int rd, input int rs, input int rt,
                       input bit ur, input bit ps, input logic [31:0] t, input logic [31:0] p);
    clr = c; ex_mem_read = mr; ex_rd = 5'(rd); id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rt = ur; mem_pcsrc = ps; targ = t; pc4 = p;
  endtask
  task automatic cycle();
    logic [31:0] e_pc;
    logic [4:0]  e_fl;
    #1;
    if (armed) begin
      if (m_st == 0) begin
        e_pc = RPC; e_fl = 5'b00111;
      end else if (mem_pcsrc) begin
        e_pc = targ; e_fl = 5'b11111;
      end else if (model_hazard()) begin
        e_pc = pc4; e_fl = 5'b00010;
      end else begin
        e_pc = pc4; e_fl = 5'b11000;
      end
      check("pc_next", pc_next, e_pc);
      check("ctl{pw,iw,iff,idf,exf}",
            {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}, {27'd0, e_fl});
    end
    @(posedge clk);
    if (clr) begin
      m_st = 0; m_left = BC; m_sc = 0; m_fc = 0;
    end else if (m_st == 0) begin
      m_left--;
      if (m_left == 0) m_st = 1;
    end else if (mem_pcsrc) begin
      m_st = 3;
      if (m_fc != MAXC) m_fc++;
    end else if (model_hazard()) begin
      m_st = 2;
      if (m_sc != MAXC) m_sc++;
    end else m_st = 1;
    armed = 1;
    @(negedge clk);
    check("ctrl_state", {30'd0, ctrl_state}, 32'(m_st));
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
  endtask
  initial begin
    m_st = 0; m_left = BC; m_sc = 0; m_fc = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 7, 7, 7, 1, 1, 32'h1234, 32'h5678);
    repeat (BC + 1) cycle();
    drive(0, 1, 5, 5, 0, 0, 0, 32'h0, 32'h0000_0010);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0014);
    cycle();
    drive(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0000_0018);
    cycle();
    drive(0, 1, 5, 1, 5, 0, 0, 32'h0, 32'h0000_001C);
    cycle();
    drive(0, 1, 5, 1, 5, 1, 0, 32'h0, 32'h0000_001C);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0000_0040, 32'h0000_0010);
    cycle();
    cycle();
    drive(0, 1, 9, 9, 0, 0, 1, 32'h0000_0080, 32'h0000_0044);
    cycle();
    force dut.Stall_Cnt = MAXC;
    #1 release dut.Stall_Cnt;
    m_sc = MAXC;
    drive(0, 1, 3, 3, 0, 0, 0, 32'h0, 32'h0000_0084);
    cycle();
    cycle();
    drive(1, 1, 3, 3, 0, 0, 0, 32'h0, 32'h0000_0084);
    cycle();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 63) == 0, 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            $urandom_range(0, 4) == 0, $urandom, $urandom);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
